// File: rtl/cc_pack_pkg.sv
// Shared types and constants for the cc lane packer: byte width, packer state
// encoding and a helper that sizes 0..N counters.
package cc_pack_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FILL  = 1'b1
  } pack_state_e;

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/cc_lane_packer_if.sv
// Bus bundle for cc_lane_packer: byte strobe in, packed-word stream out, status.
// Optional out_parity is present only when CC_PACK_PARITY_EN is defined.
interface cc_lane_packer_if #(
  parameter int BYTES = 4,
  parameter int DEPTH = 4
);
  import cc_pack_pkg::*;

  logic                       in_valid;
  logic [BYTE_W-1:0]          in_data;
  logic                       in_flush;
  // out side: a word transfers on every cycle with out_valid && out_ready; while
  // out_valid is high and out_ready low, out_data/out_count stay unchanged.
  logic                       out_valid;
  logic                       out_ready;
  logic [BYTE_W*BYTES-1:0]    out_data;
  logic [cnt_w(BYTES)-1:0]    out_count;
  logic [cnt_w(DEPTH)-1:0]    fifo_level;
  logic                       ovf;
  logic                       ovf_clr;
  pack_state_e                dbg_state;
`ifdef CC_PACK_PARITY_EN
  logic [BYTES-1:0]           out_parity;
`endif

  modport slave (
    input  in_valid, in_data, in_flush, out_ready, ovf_clr,
    output out_valid, out_data, out_count, fifo_level, ovf, dbg_state
`ifdef CC_PACK_PARITY_EN
    , output out_parity
`endif
  );

  modport master (
    output in_valid, in_data, in_flush, out_ready, ovf_clr,
    input  out_valid, out_data, out_count, fifo_level, ovf, dbg_state
`ifdef CC_PACK_PARITY_EN
    , input out_parity
`endif
  );

endinterface

// File: rtl/cc_sync_fifo.sv
// Single-clock FIFO; a push into a full FIFO is accepted only when a pop happens
// in the same cycle.
module cc_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           wdata_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] level_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]    level_q;
  logic             do_push, do_pop;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign rdata_o = mem_q[rd_ptr_q];
  assign do_push = push_i && (!full_o || pop_i);
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q <= level_q + LW'(do_push) - LW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/cc_lane_packer.sv
// Packs strobed bytes from the decode stage into BYTES-wide words and queues them.
// Define CC_PACK_PARITY_EN to add per-byte even parity on out_parity.
module cc_lane_packer
  import cc_pack_pkg::*;
#(
  parameter int BYTES = 4,
  parameter int DEPTH = 4
) (
  input logic             clk,
  input logic             rst,
  cc_lane_packer_if.slave bus
);
  localparam int CW = cnt_w(BYTES);
  localparam int DW = BYTE_W * BYTES;
`ifdef CC_PACK_PARITY_EN
  localparam int EW = DW + CW + BYTES;
`else
  localparam int EW = DW + CW;
`endif

  pack_state_e                   state_q, state_d;
  logic [BYTES-1:0][BYTE_W-1:0]  buf_q, buf_d;
  logic [CW-1:0]                 cnt_q, cnt_d;
  logic                          ovf_q, ovf_d;
  logic                          push;
  logic [BYTES-1:0][BYTE_W-1:0]  push_word;
  logic [CW-1:0]                 push_cnt;
  logic [EW-1:0]                 wdata, rdata;
  logic                          full, empty, pop;

  // Bytes above the fill point are kept at zero so a word can be pushed as-is.
  always_comb begin
    state_d   = state_q;
    buf_d     = buf_q;
    cnt_d     = cnt_q;
    push      = 1'b0;
    push_word = buf_q;
    push_cnt  = cnt_q;
    if (bus.in_valid) begin
      for (int i = 0; i < BYTES; i++) begin
        if (cnt_q == CW'(i)) push_word[i] = bus.in_data;
      end
      push_cnt = cnt_q + CW'(1);
      if (bus.in_flush || cnt_q == CW'(BYTES - 1)) begin
        push    = 1'b1;
        state_d = EMPTY;
        buf_d   = '0;
        cnt_d   = '0;
      end else begin
        state_d = FILL;
        buf_d   = push_word;
        cnt_d   = push_cnt;
      end
    end else if (bus.in_flush && state_q == FILL) begin
      push    = 1'b1;
      state_d = EMPTY;
      buf_d   = '0;
      cnt_d   = '0;
    end
  end

  assign pop   = !empty && bus.out_ready;
  assign ovf_d = (push && full && !pop) ? 1'b1 : (bus.ovf_clr ? 1'b0 : ovf_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      buf_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

`ifdef CC_PACK_PARITY_EN
  logic [BYTES-1:0] par;
  always_comb begin
    par = '0;
    for (int i = 0; i < BYTES; i++) par[i] = ^push_word[i];
  end
  assign wdata          = {par, push_cnt, push_word};
  assign bus.out_parity = empty ? '0 : rdata[EW-1:DW+CW];
`else
  assign wdata = {push_cnt, push_word};
`endif

  cc_sync_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (wdata),
    .rdata_o (rdata),
    .full_o  (full),
    .empty_o (empty),
    .level_o (bus.fifo_level)
  );

  assign bus.out_valid = !empty;
  assign bus.out_data  = empty ? '0 : rdata[DW-1:0];
  assign bus.out_count = empty ? '0 : rdata[DW+CW-1:DW];
  assign bus.ovf       = ovf_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_cc_lane_packer.sv
// Bench for cc_lane_packer: directed scenarios followed by random traffic, all
// checked each cycle against a queue-based model of the packer and FIFO.
module tb_cc_lane_packer;
  import cc_pack_pkg::*;

  localparam int BYTES = 4;
  localparam int DEPTH = 4;
  localparam int DW    = 8 * BYTES;
  localparam int CW    = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cc_lane_packer_if #(.BYTES(BYTES), .DEPTH(DEPTH)) bus ();

  cc_lane_packer #(.BYTES(BYTES), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [CW+DW-1:0] exp_q[$];
  logic [7:0]       pend[$];
  logic             m_ovf = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock of the reference: pop first, then append the byte, close a word
  // when it is full or flushed, and drop it if the queue was full with no pop.
  task automatic model_step(input logic v, input logic [7:0] d, input logic f,
                            input logic r, input logic c, input logic rs);
    logic          was_full, popped, set_ovf, have_word;
    logic [DW-1:0] w;
    int            n;
    if (rs) begin
      exp_q.delete();
      pend.delete();
      m_ovf = 1'b0;
      return;
    end
    was_full  = (exp_q.size() == DEPTH);
    popped    = (exp_q.size() > 0) && r;
    set_ovf   = 1'b0;
    have_word = 1'b0;
    w         = '0;
    n         = 0;
    if (v) pend.push_back(d);
    if (pend.size() == BYTES || (f && pend.size() > 0)) begin
      n = pend.size();
      for (int i = 0; i < n; i++) w = w | (DW'(pend[i]) << (8 * i));
      pend.delete();
      have_word = 1'b1;
    end
    if (popped) void'(exp_q.pop_front());
    if (have_word) begin
      if (was_full && !popped) set_ovf = 1'b1;
      else exp_q.push_back({CW'(n), w});
    end
    m_ovf = set_ovf ? 1'b1 : (c ? 1'b0 : m_ovf);
  endtask

  task automatic check_outputs();
    logic [CW+DW-1:0] head;
    head = (exp_q.size() > 0) ? exp_q[0] : '0;
    check_eq("out_valid", bus.out_valid, exp_q.size() != 0);
    check_eq("out_data", bus.out_data, head[DW-1:0]);
    check_eq("out_count", bus.out_count, head[CW+DW-1:DW]);
    check_eq("fifo_level", bus.fifo_level, exp_q.size());
    check_eq("ovf", bus.ovf, m_ovf);
    check_eq("state", bus.dbg_state, pend.size() != 0);
`ifdef CC_PACK_PARITY_EN
    for (int i = 0; i < BYTES; i++)
      check_eq("out_parity", bus.out_parity[i], ^head[8*i +: 8]);
`endif
  endtask

  task automatic cycle(input logic v, input logic [7:0] d, input logic f,
                       input logic r, input logic c = 1'b0, input logic rs = 1'b0);
    bus.in_valid = v;
    bus.in_data  = d;
    bus.in_flush = f;
    bus.out_ready = r;
    bus.ovf_clr  = c;
    rst          = rs;
    @(posedge clk);
    model_step(v, d, f, r, c, rs);
    #1;
    check_outputs();
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_flush  = 1'b0;
    bus.out_ready = 1'b0;
    bus.ovf_clr   = 1'b0;

    cycle(0, 8'h00, 0, 0, 0, 1);
    cycle(0, 8'h00, 0, 0, 0, 1);
    check_eq("rst_out_valid", bus.out_valid, 0);
    check_eq("rst_out_data", bus.out_data, 0);
    check_eq("rst_level", bus.fifo_level, 0);
    check_eq("rst_ovf", bus.ovf, 0);

    // Full word with consumer ready
    cycle(1, 8'h11, 0, 1);
    cycle(1, 8'h22, 0, 1);
    cycle(1, 8'h33, 0, 1);
    cycle(1, 8'h44, 0, 1);
    check_eq("t1_data", bus.out_data, 32'h44332211);
    check_eq("t1_count", bus.out_count, 4);
    cycle(0, 8'h00, 0, 1);

    // Partial word by flush, then flush on EMPTY
    cycle(1, 8'hA5, 0, 0);
    cycle(1, 8'h5A, 0, 0);
    cycle(0, 8'h00, 1, 0);
    check_eq("t2_data", bus.out_data, 32'h00005AA5);
    check_eq("t2_count", bus.out_count, 2);
    cycle(0, 8'h00, 1, 0);
    check_eq("t2_empty_flush_level", bus.fifo_level, 1);
    cycle(0, 8'h00, 0, 1);

    // Byte and flush together on EMPTY
    cycle(1, 8'h77, 1, 0);
    check_eq("t3_data", bus.out_data, 32'h00000077);
    check_eq("t3_count", bus.out_count, 1);
    cycle(0, 8'h00, 0, 1);

    // Overflow: five words into a four-entry FIFO
    for (int w = 0; w < 5; w++)
      for (int b = 0; b < BYTES; b++)
        cycle(1, 8'(w * 16 + b), 0, 0);
    check_eq("t4_level", bus.fifo_level, 4);
    check_eq("t4_ovf", bus.ovf, 1);
    check_eq("t4_head", bus.out_data, 32'h03020100);
    cycle(0, 8'h00, 0, 0, 1);
    check_eq("t4_ovf_clr", bus.ovf, 0);

    // Push and pop in the same cycle while full
    cycle(1, 8'hC0, 0, 0);
    cycle(1, 8'hC1, 0, 0);
    cycle(1, 8'hC2, 0, 0);
    cycle(1, 8'hC3, 0, 1);
    check_eq("t5_level", bus.fifo_level, 4);
    check_eq("t5_ovf", bus.ovf, 0);
    check_eq("t5_head", bus.out_data, 32'h13121110);
    for (int i = 0; i < 4; i++) cycle(0, 8'h00, 0, 1);
    check_eq("t5_drained", bus.fifo_level, 0);

    // Reset mid-word with words queued
    for (int i = 0; i < 11; i++) cycle(1, 8'(8'h60 + i), 0, 0);
    cycle(0, 8'h00, 0, 0, 0, 1);
    check_eq("t6_out_valid", bus.out_valid, 0);
    check_eq("t6_level", bus.fifo_level, 0);
    cycle(1, 8'hD1, 0, 0);
    cycle(1, 8'hD2, 0, 0);
    cycle(1, 8'hD3, 0, 0);
    cycle(1, 8'hD4, 0, 0);
    check_eq("t6_data", bus.out_data, 32'hD4D3D2D1);
    check_eq("t6_count", bus.out_count, 4);

    // Random traffic
    repeat (3000) begin
      cycle($urandom_range(0, 99) < 60,
            8'($urandom_range(0, 255)),
            $urandom_range(0, 99) < 8,
            $urandom_range(0, 99) < 45,
            $urandom_range(0, 99) < 3,
            $urandom_range(0, 399) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
